// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the single-issue core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB around the
// combinational decoder. It raises strobes toward imem, the ALU, dmem, the
// register file and the PC.
// Optional feature macro: CORE_PERF_CNT_EN adds the o_cycle_cnt/o_retire_cnt
// performance counters.
//
// Handshakes: o_fetch_req and o_mem_req are held high until the matching
// completion input (i_inst_ready / i_mem_done) is seen high on a rising edge.
// That edge completes the transfer. i_alu_done completes EXEC the same way,
// and may already be high in the o_alu_start cycle. Completion inputs seen
// outside their own state are ignored.
module core_sequencer #(
    parameter int ALU_MAX_CYCLES = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_fetch_req,
    input  logic       i_inst_ready,
    output logic       o_inst_latch,
    input  logic       i_dec_alu,
    input  logic       i_dec_mem,
    input  logic       i_dec_store,
    input  logic       i_dec_jump,
    input  logic       i_dec_branch,
    input  logic       i_dec_subst,
    output logic       o_alu_start,
    input  logic       i_alu_done,
    output logic       o_mem_req,
    output logic       o_mem_we,
    input  logic       i_mem_done,
    output logic       o_reg_we,
    output logic       o_pc_we,
    output logic       o_illegal,
    output logic [2:0] o_state
`ifdef CORE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] o_cycle_cnt,
    output logic [CNT_WIDTH-1:0] o_retire_cnt
`endif
);

    // Timeout counter must be able to hold ALU_MAX_CYCLES-1.
    localparam int TW = $clog2(ALU_MAX_CYCLES) + 1;
    localparam logic [TW-1:0] LAST_EXEC = TW'(ALU_MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_illegal;
    logic [TW-1:0] r_cnt;
    logic          w_set_illegal;

    // State register, sticky trap flag and EXEC timeout counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            // EXEC is only entered from DECODE, so that is where the count restarts.
            if (r_state == S_DECODE) begin
                r_cnt <= '0;
            end else if (r_state == S_EXEC) begin
                r_cnt <= r_cnt + TW'(1);
            end
        end
    end

    // Next-state and strobe decode; strobes depend on the current state only,
    // plus the decoder flags and handshake inputs of that state.
    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        o_fetch_req   = 1'b0;
        o_inst_latch  = 1'b0;
        o_alu_start   = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_reg_we      = 1'b0;
        o_pc_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                o_fetch_req = 1'b1;
                if (i_inst_ready) begin
                    o_inst_latch = 1'b1;
                    w_next       = S_DECODE;
                end
            end
            S_DECODE: begin
                if (i_dec_mem) begin
                    w_next = S_MEM;
                end else if (i_dec_alu) begin
                    w_next = S_EXEC;
                end else if (i_dec_jump || i_dec_branch || i_dec_subst) begin
                    w_next = S_WB;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = S_HALT;
                end
            end
            S_EXEC: begin
                o_alu_start = (r_cnt == '0);
                if (i_alu_done) begin
                    w_next = S_WB;
                end else if (r_cnt == LAST_EXEC) begin
                    w_set_illegal = 1'b1;
                    w_next        = S_HALT;
                end
            end
            S_MEM: begin
                o_mem_req = 1'b1;
                o_mem_we  = i_dec_store;
                if (i_mem_done) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                o_pc_we  = 1'b1;
                o_reg_we = !(i_dec_store || i_dec_branch);
                w_next   = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign o_illegal = r_illegal;
    assign o_state   = r_state;

`ifdef CORE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic [CNT_WIDTH-1:0] r_retire_cnt;

    // Busy-cycle and retired-instruction counters; both wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (r_state != S_IDLE && r_state != S_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
            end
            if (r_state == S_WB) begin
                r_retire_cnt <= r_retire_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_cycle_cnt  = r_cycle_cnt;
    assign o_retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed sequences plus randomized
// instructions checked by a scoreboard against a per-instruction model.
module tb_core_sequencer;

  localparam int W = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic i_inst_ready = 1'b0;
  logic i_dec_alu = 1'b0, i_dec_mem = 1'b0, i_dec_store = 1'b0;
  logic i_dec_jump = 1'b0, i_dec_branch = 1'b0, i_dec_subst = 1'b0;
  logic i_alu_done = 1'b0, i_mem_done = 1'b0;
  logic o_fetch_req, o_inst_latch, o_alu_start, o_mem_req, o_mem_we;
  logic o_reg_we, o_pc_we, o_illegal;
  logic [2:0] o_state;
`ifdef CORE_PERF_CNT_EN
  logic [31:0] o_cycle_cnt, o_retire_cnt;
`endif

  core_sequencer dut (
    .i_clk(clk), .i_rst(rst),
    .o_fetch_req(o_fetch_req), .i_inst_ready(i_inst_ready), .o_inst_latch(o_inst_latch),
    .i_dec_alu(i_dec_alu), .i_dec_mem(i_dec_mem), .i_dec_store(i_dec_store),
    .i_dec_jump(i_dec_jump), .i_dec_branch(i_dec_branch), .i_dec_subst(i_dec_subst),
    .o_alu_start(o_alu_start), .i_alu_done(i_alu_done),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .i_mem_done(i_mem_done),
    .o_reg_we(o_reg_we), .o_pc_we(o_pc_we), .o_illegal(o_illegal), .o_state(o_state)
`ifdef CORE_PERF_CNT_EN
    , .o_cycle_cnt(o_cycle_cnt), .o_retire_cnt(o_retire_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  // Expected per-instruction record:
  // [32] reg_we, [31:24] total cycles FETCH..WB, [23:16] mem_req cycles,
  // [15:8] mem_we cycles, [7:0] alu_start pulses.
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_inst_ready = 1'b0; i_alu_done = 1'b0; i_mem_done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_flags(input logic [5:0] f);
    {i_dec_alu, i_dec_mem, i_dec_store, i_dec_jump, i_dec_branch, i_dec_subst} = f;
  endtask

  // Bounded wait (at negedges) for one of the DUT's state-derived strobes.
  task automatic wait_sig(input int which, input string name);
    int n;
    logic s;
    n = 0;
    forever begin
      case (which)
        0: s = o_fetch_req;
        1: s = o_alu_start;
        2: s = o_mem_req;
        default: s = o_pc_we;
      endcase
      if (s) break;
      if (n == 200) begin
        check({"timeout_", name}, 0, 1);
        break;
      end
      n++;
      step();
    end
  endtask

  // ---------------- reference model ----------------
  // Flag order: {alu, mem, store, jump, branch, subst}.
  function automatic logic [W-1:0] model(input logic [5:0] f, input int fw, input int aw,
                                          input int mw);
    logic alu, mem, store, branch;
    int cyc, memc, wec, alus;
    alu = f[5]; mem = f[4]; store = f[3]; branch = f[1];
    cyc  = (fw + 1) + 1 + 1;        // FETCH wait + DECODE + WB
    memc = 0; wec = 0; alus = 0;
    if (mem) begin
      memc = mw + 1;
      cyc += memc;
      if (store) wec = memc;
    end else if (alu) begin
      alus = 1;
      cyc += aw + 1;
    end
    return {!(store || branch), 8'(cyc), 8'(memc), 8'(wec), 8'(alus)};
  endfunction

  // ---------------- driver ----------------
  // Starts at a negedge in FETCH (or IDLE) and returns at the negedge after WB.
  task automatic do_instr(input logic [5:0] f, input int fw, input int aw, input int mw);
    exp_q.push_back(model(f, fw, aw, mw));
    set_flags(f);
    wait_sig(0, "fetch");
    repeat (fw) step();
    i_inst_ready = 1'b1;
    step();
    i_inst_ready = 1'b0;
    if (f[4]) begin
      wait_sig(2, "mem_req");
      repeat (mw) step();
      i_mem_done = 1'b1;
      step();
      i_mem_done = 1'b0;
    end else if (f[5]) begin
      wait_sig(1, "alu_start");
      repeat (aw) step();
      i_alu_done = 1'b1;
      step();
      i_alu_done = 1'b0;
    end
    wait_sig(3, "wb");
    step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  int obs_cyc, obs_latch, obs_alu, obs_mem, obs_we;
  always @(negedge clk) begin
    logic [W-1:0] e;
    #2;
    if (!mon_en || rst || o_state == 3'd0) begin
      obs_cyc = 0; obs_latch = 0; obs_alu = 0; obs_mem = 0; obs_we = 0;
    end else begin
      obs_cyc++;
      if (o_inst_latch) obs_latch++;
      if (o_alu_start) obs_alu++;
      if (o_mem_req) obs_mem++;
      if (o_mem_we) obs_we++;
      if (o_reg_we && !o_pc_we) check("reg_we_outside_wb", 1, 0);
      if (o_fetch_req && o_mem_req) check("fetch_and_mem_overlap", 1, 0);
      if (o_pc_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wb_reg_we", int'(o_reg_we), int'(e[32]));
          check("instr_cycles", obs_cyc, int'(e[31:24]));
          check("mem_req_cycles", obs_mem, int'(e[23:16]));
          check("mem_we_cycles", obs_we, int'(e[15:8]));
          check("alu_start_pulses", obs_alu, int'(e[7:0]));
          check("inst_latch_pulses", obs_latch, 1);
        end
        obs_cyc = 0; obs_latch = 0; obs_alu = 0; obs_mem = 0; obs_we = 0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int seq[6];
    int n;
    logic [5:0] f;
    seq = '{0, 1, 2, 3, 5, 1};

    // Reset state: all strobes low, IDLE, no trap.
    step();
    check("rst_state", int'(o_state), 0);
    check("rst_illegal", int'(o_illegal), 0);
    check("rst_strobes", int'({o_fetch_req, o_inst_latch, o_alu_start, o_mem_req,
                               o_mem_we, o_reg_we, o_pc_we}), 0);

    // ALU with zero-wait handshakes: state trace and WB strobes.
    do_reset();
    set_flags(6'b100000);
    i_inst_ready = 1'b1;
    i_alu_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("alu_seq_state_%0d", i), int'(o_state), seq[i]);
      check($sformatf("alu_seq_pc_we_%0d", i), int'(o_pc_we), int'(seq[i] == 5));
      check($sformatf("alu_seq_reg_we_%0d", i), int'(o_reg_we), int'(seq[i] == 5));
      step();
    end

    // Scoreboarded instructions: directed classes first, then random.
    do_reset();
    set_flags(6'b000000);
    mon_en = 1'b1;
    do_instr(6'b010000, 0, 0, 2);   // load, mem_done after 3 cycles
    do_instr(6'b011000, 1, 0, 1);   // store
    do_instr(6'b000010, 0, 0, 0);   // branch
    do_instr(6'b000100, 2, 0, 0);   // jump
    do_instr(6'b000001, 0, 0, 0);   // subst
    do_instr(6'b100000, 0, 0, 0);   // alu, done same cycle as start
    do_instr(6'b100000, 0, 5, 0);   // alu, slow
    do_instr(6'b110111, 0, 3, 0);   // mem beats alu and the rest
    do_instr(6'b100110, 0, 1, 0);   // alu beats jump/branch, branch kills reg_we
    for (int i = 0; i < 60; i++) begin
      f = 6'($urandom_range(1, 31));
      f = {f[4], f[3], f[3] & f[2], f[1], f[0], 1'b0};
      if (f == 6'b0) f = 6'b000001;
      if ($urandom_range(0, 3) == 0) f[0] = 1'b1;
      do_instr(f, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 4));
    end
    step();
    mon_en = 1'b0;
    check("scoreboard_drained", exp_q.size(), 0);

    // No class flag in DECODE: trap, HALT held regardless of inputs.
    do_reset();
    set_flags(6'b000000);
    i_inst_ready = 1'b1;
    step(); step(); step();
    check("illegal_flag", int'(o_illegal), 1);
    check("illegal_state", int'(o_state), 6);
    for (int i = 0; i < 20; i++) begin
      set_flags(6'($urandom));
      i_inst_ready = 1'($urandom); i_alu_done = 1'($urandom); i_mem_done = 1'($urandom);
      step();
      check("halt_held", int'({o_state, o_illegal}), 13);
      check("halt_strobes", int'({o_fetch_req, o_inst_latch, o_alu_start, o_mem_req,
                                  o_mem_we, o_reg_we, o_pc_we}), 0);
    end
    rst = 1'b1;
    step();
    check("halt_rst_state", int'(o_state), 0);
    check("halt_rst_illegal", int'(o_illegal), 0);

    // ALU timeout: exactly ALU_MAX_CYCLES cycles in EXEC, then trap.
    do_reset();
    set_flags(6'b100000);
    i_inst_ready = 1'b1;
    n = 0;
    while (o_state != 3'd3 && n < 20) begin n++; step(); end
    i_inst_ready = 1'b0;
    check("timeout_alu_start_first", int'(o_alu_start), 1);
    n = 0;
    while (o_state == 3'd3 && n < 200) begin
      if (n > 0 && o_alu_start) check("timeout_alu_start_repeat", 1, 0);
      n++;
      step();
    end
    check("timeout_exec_cycles", n, 64);
    check("timeout_state", int'(o_state), 6);
    check("timeout_illegal", int'(o_illegal), 1);

    // Reset during MEM drops mem_req on the next cycle.
    do_reset();
    set_flags(6'b011000);
    i_inst_ready = 1'b1;
    wait_sig(2, "rst_mem_req");
    i_inst_ready = 1'b0;
    step();
    check("mem_wait_req", int'(o_mem_req), 1);
    check("mem_wait_we", int'(o_mem_we), 1);
    rst = 1'b1;
    step();
    check("rst_mid_mem_req", int'(o_mem_req), 0);
    check("rst_mid_state", int'(o_state), 0);
    rst = 1'b0;
    step();
    check("rst_mid_recover_fetch", int'(o_fetch_req), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
